// File: rtl/sync_fifo_prog_if.sv
// sync_fifo_prog_if: write/read/status bundle between a FIFO and its client.
interface sync_fifo_prog_if #(
  parameter int DEPTH_WIDTH = 10,
  parameter int DATA_WIDTH  = 32
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_empty;
  logic                  almost_empty;
  logic [DEPTH_WIDTH:0]  water_level;
  logic [DEPTH_WIDTH:0]  af_level;
  logic [DEPTH_WIDTH:0]  ae_level;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;
  modport master (
    output flush, wr_en, wr_data, rd_en, af_level, ae_level, err_clr,
    input  wr_full, almost_full, rd_data, rd_empty, almost_empty, water_level, overflow, underflow
  );
  modport slave (
    input  flush, wr_en, wr_data, rd_en, af_level, ae_level, err_clr,
    output wr_full, almost_full, rd_data, rd_empty, almost_empty, water_level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost flags, level output,
// flush, sticky error flags and standard or first-word-fall-through read.
module sync_fifo_prog #(
  parameter int DEPTH_WIDTH = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int FWFT        = 0
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_prog_if.slave f
);
  localparam logic [DEPTH_WIDTH:0] DEPTH = {1'b1, {DEPTH_WIDTH{1'b0}}};
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_WIDTH:0]   wr_ptr, rd_ptr, level;
  logic [DEPTH_WIDTH-1:0] rd_idx;
  logic                   wr_acc, rd_acc, wr_err, rd_err;
  assign f.wr_full      = level == DEPTH;
  assign f.rd_empty     = level == '0;
  assign f.almost_full  = level >= f.af_level;
  assign f.almost_empty = level <= f.ae_level;
  assign f.water_level  = level;
  assign rd_idx         = rd_ptr[DEPTH_WIDTH-1:0];
  // flush suppresses both the transfers and the error detection of its cycle
  assign wr_acc = f.wr_en & ~f.wr_full & ~f.flush;
  assign rd_acc = f.rd_en & ~f.rd_empty & ~f.flush;
  assign wr_err = f.wr_en & f.wr_full & ~f.flush;
  assign rd_err = f.rd_en & f.rd_empty & ~f.flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      f.overflow  <= 1'b0;
      f.underflow <= 1'b0;
    end else begin
      wr_ptr      <= f.flush ? '0 : wr_ptr + (DEPTH_WIDTH+1)'(wr_acc);
      rd_ptr      <= f.flush ? '0 : rd_ptr + (DEPTH_WIDTH+1)'(rd_acc);
      level       <= f.flush ? '0 : level + (DEPTH_WIDTH+1)'(wr_acc) - (DEPTH_WIDTH+1)'(rd_acc);
      f.overflow  <= wr_err | (f.overflow & ~f.err_clr);
      f.underflow <= rd_err | (f.underflow & ~f.err_clr);
    end
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr[DEPTH_WIDTH-1:0]] <= f.wr_data;
  if (FWFT != 0) begin : g_fwft
    assign f.rd_data = mem[rd_idx];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) rd_q <= '0;
      else if (f.flush) rd_q <= '0;
      else if (rd_acc) rd_q <= mem[rd_idx];
    assign f.rd_data = rd_q;
  end
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: vector table on a 16x8 standard FIFO plus directed
// sequences for fall-through reads and asynchronous reset.
module tb_sync_fifo_prog;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sync_fifo_prog_if #(.DEPTH_WIDTH(4), .DATA_WIDTH(8)) f0 ();
  sync_fifo_prog_if #(.DEPTH_WIDTH(4), .DATA_WIDTH(8)) f1 ();
  sync_fifo_prog #(.DEPTH_WIDTH(4), .DATA_WIDTH(8), .FWFT(0)) dut0 (.clk(clk), .rst(rst), .f(f0.slave));
  sync_fifo_prog #(.DEPTH_WIDTH(4), .DATA_WIDTH(8), .FWFT(1)) dut1 (.clk(clk), .rst(rst), .f(f1.slave));
  typedef struct {
    bit         wr, rd, fl, ec;
    logic [7:0] din;
    int         lvl;
    bit         ovf, unf, dchk;
    logic [7:0] dat;
  } vec_t;
  vec_t tv[$];
  int total = 0, passed = 0;
  task automatic chk(string n, int idx, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s [%0d]: got %0h expected %0h", n, idx, act, exp);
  endtask
  function automatic void add(bit wr, bit rd, bit fl, bit ec, logic [7:0] din, int lvl,
                              bit ovf, bit unf, bit dchk, logic [7:0] dat);
    tv.push_back('{wr, rd, fl, ec, din, lvl, ovf, unf, dchk, dat});
  endfunction
  task automatic chk0(string t, int idx, int lvl, bit ovf, bit unf, bit dchk, logic [7:0] dat);
    chk({t, ".level"}, idx, int'(f0.water_level), lvl);
    chk({t, ".full"}, idx, int'(f0.wr_full), int'(lvl == 16));
    chk({t, ".empty"}, idx, int'(f0.rd_empty), int'(lvl == 0));
    chk({t, ".afull"}, idx, int'(f0.almost_full), int'(lvl >= 12));
    chk({t, ".aempty"}, idx, int'(f0.almost_empty), int'(lvl <= 3));
    chk({t, ".ovf"}, idx, int'(f0.overflow), int'(ovf));
    chk({t, ".unf"}, idx, int'(f0.underflow), int'(unf));
    if (dchk) chk({t, ".data"}, idx, int'(f0.rd_data), int'(dat));
  endtask
  task automatic drive0(bit wr, bit rd, bit fl, bit ec, logic [7:0] din);
    f0.wr_en = wr; f0.rd_en = rd; f0.flush = fl; f0.err_clr = ec; f0.wr_data = din;
  endtask
  task automatic step0(bit wr, bit rd, bit fl, bit ec, logic [7:0] din);
    drive0(wr, rd, fl, ec, din);
    @(posedge clk); #1;
  endtask
  task automatic step1(bit wr, bit rd, bit ec, logic [7:0] din);
    f1.wr_en = wr; f1.rd_en = rd; f1.err_clr = ec; f1.wr_data = din;
    @(posedge clk); #1;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 8'(i), i + 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'hFF, 16, 1, 0, 0, 0);
    add(0, 0, 0, 1, 8'h00, 16, 0, 0, 0, 0);
    for (int j = 0; j < 16; j++) add(0, 1, 0, 0, 8'h00, 15 - j, 0, 0, 1, 8'(j));
    add(0, 1, 0, 0, 8'h00, 0, 0, 1, 1, 8'h0F);
    for (int i = 0; i < 8; i++) add(1, 0, 0, 0, 8'(32 + i), i + 1, 0, 1, 0, 0);
    for (int k = 0; k < 40; k++) add(1, 1, 0, 0, 8'(40 + k), 8, 0, 1, 1, 8'(32 + k));
    add(1, 0, 0, 0, 8'h50, 9, 0, 1, 0, 0);
    add(1, 0, 0, 0, 8'h51, 10, 0, 1, 0, 0);
    add(1, 1, 1, 0, 8'h77, 0, 0, 1, 1, 8'h00);
    add(0, 1, 0, 1, 8'h00, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0);
    drive0(0, 0, 0, 0, 8'h00);
    f0.af_level = 5'd12; f0.ae_level = 5'd3;
    f1.af_level = 5'd12; f1.ae_level = 5'd3;
    f1.flush = 1'b0; f1.wr_en = 1'b0; f1.rd_en = 1'b0; f1.err_clr = 1'b0; f1.wr_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk0("reset", 0, 0, 0, 0, 1, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      step0(tv[i].wr, tv[i].rd, tv[i].fl, tv[i].ec, tv[i].din);
      chk0("vec", i, tv[i].lvl, tv[i].ovf, tv[i].unf, tv[i].dchk, tv[i].dat);
    end
    drive0(0, 0, 0, 0, 8'h00);
    step1(1, 0, 0, 8'hA5);
    chk("fwft.empty", 0, int'(f1.rd_empty), 0);
    chk("fwft.data", 0, int'(f1.rd_data), 'hA5);
    step1(0, 1, 0, 8'h00);
    chk("fwft.empty", 1, int'(f1.rd_empty), 1);
    chk("fwft.unf", 1, int'(f1.underflow), 0);
    step1(0, 1, 0, 8'h00);
    chk("fwft.unf", 2, int'(f1.underflow), 1);
    step1(1, 0, 1, 8'h11);
    chk("fwft.unf", 3, int'(f1.underflow), 0);
    step1(1, 0, 0, 8'h22);
    chk("fwft.data", 4, int'(f1.rd_data), 'h11);
    chk("fwft.level", 4, int'(f1.water_level), 2);
    step1(0, 1, 0, 8'h00);
    chk("fwft.data", 5, int'(f1.rd_data), 'h22);
    chk("fwft.level", 5, int'(f1.water_level), 1);
    step1(0, 0, 0, 8'h00);
    step0(0, 1, 0, 0, 8'h00);
    chk0("pre_rst", 0, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 7; i++) step0(1, 0, 0, 0, 8'(96 + i));
    chk0("burst", 0, 7, 0, 1, 0, 8'h00);
    step0(0, 1, 0, 0, 8'h00);
    chk0("burst", 1, 6, 0, 1, 1, 8'h60);
    drive0(1, 0, 0, 0, 8'h67);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk0("async_rst", 0, 0, 0, 0, 1, 8'h00);
    drive0(0, 0, 0, 0, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    step0(1, 0, 0, 0, 8'h3C);
    chk0("post_rst", 0, 1, 0, 0, 0, 8'h00);
    step0(0, 1, 0, 0, 8'h00);
    chk0("post_rst", 1, 0, 0, 0, 1, 8'h3C);
    drive0(0, 0, 0, 0, 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO. It is the next-generation successor to the fixed 1024x32 IP FIFOs and is built as plain RTL rather than a vendor primitive. Width, depth and read mode (standard or first-word-fall-through) are generic. The block adds runtime-programmable almost thresholds, a water level output, synchronous flush, and sticky overflow/underflow error flags. It buffers streams between same-clock producer/consumer blocks in the SoC peripheral subsystem, such as the video and audio paths.

Parameters:
- DEPTH_WIDTH, 10, log2 of entry count; DEPTH = 2**DEPTH_WIDTH; legal 2..16.
- DATA_WIDTH, 32, word width; legal 1..1024.
- FWFT, 0, 0 = standard read (registered data, 1-cycle latency); 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- wr_full  out  1  level == DEPTH.
- almost_full  out  1  level >= af_level.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  read word.
- rd_empty  out  1  level == 0.
- almost_empty  out  1  level <= ae_level.
- water_level  out  DEPTH_WIDTH+1  current entry count, 0..DEPTH.
- af_level  in  DEPTH_WIDTH+1  almost-full threshold; quasi-static.
- ae_level  in  DEPTH_WIDTH+1  almost-empty threshold; quasi-static.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- err_clr  in  1  clears overflow/underflow.

Behaviour:
- Storage: DEPTH x DATA_WIDTH array.
- Pointers: wr_ptr and rd_ptr, each DEPTH_WIDTH+1 bits; they wrap naturally at 2*DEPTH.
- Level: level = wr_ptr - rd_ptr (modulo 2**(DEPTH_WIDTH+1)). It is held in a register updated each cycle; water_level = level.
- Write accept: wr_acc = wr_en & ~wr_full. A write while full is dropped, even if a read is accepted in the same cycle.
- Read accept: rd_acc = rd_en & ~rd_empty. A read while empty is dropped, even if a write is accepted in the same cycle.
- Level update:
  - wr_acc & ~rd_acc: level +1.
  - rd_acc & ~wr_acc: level -1.
  - Both accepted: level unchanged; both pointers advance.
- Flags:
  - wr_full, rd_empty, almost_full and almost_empty are decoded combinationally from the level register and the thresholds.
  - A flag reflects an accepted operation in the cycle after the accepting edge.
- Standard mode (FWFT=0):
  - rd_data is registered: on rd_acc at edge N, mem[rd_ptr] appears after edge N.
  - rd_data holds its value otherwise, including on a rejected read.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr[DEPTH_WIDTH-1:0]] combinationally; it is valid whenever rd_empty = 0.
  - A write at edge N into an empty FIFO gives rd_empty = 0 with that word on rd_data after edge N.
  - rd_en pops the head word.
- Flush:
  - flush = 1 at edge N sets wr_ptr, rd_ptr and level to 0; in standard mode rd_data is also set to 0.
  - flush overrides wr_en and rd_en in the same cycle; neither operation is performed and neither can set an error flag.
  - Error flags are NOT cleared by flush.
- Error flags:
  - overflow sets the cycle after wr_en & wr_full; underflow sets the cycle after rd_en & rd_empty.
  - err_clr clears both.
  - If err_clr and a new error occur in the same cycle, set wins.
- Reset (rst = 1, asynchronous):
  - Pointers, level, overflow, underflow and rd_data all go to 0.
  - Resulting outputs: rd_empty = 1, wr_full = 0, water_level = 0, almost_empty = 1, almost_full = (af_level == 0).
  - Array contents are not reset.
  - Reset mid-burst discards all contents; the first accepted write after release lands at address 0.
- Thresholds:
  - af_level > DEPTH gives almost_full = 0 permanently.
  - ae_level >= DEPTH gives almost_empty = 1 permanently.
  - Comparisons are unsigned.

Test Plan:
1. DEPTH_WIDTH=4, DATA_WIDTH=8, FWFT=0; write 0x00..0x0F on 16 consecutive cycles.
   -> wr_full = 1 after the 16th edge; water_level = 16.
   -> A 17th wr_en sets overflow = 1; level stays 16.
   -> Reading 16 words returns 0x00..0x0F, each 1 cycle after its rd_en.
2. Same config; keep level at 8, then assert wr_en and rd_en together for 40 cycles (pointers wrap twice).
   -> water_level stays 8 throughout.
   -> Read data is strictly sequential with no loss across the wrap.
3. FWFT=1; single write 0xA5 into an empty FIFO.
   -> After the next edge: rd_empty = 0, rd_data = 0xA5 with no rd_en asserted.
   -> rd_en then gives rd_empty = 1.
   -> A further rd_en sets underflow = 1.
4. af_level=12, ae_level=3; fill from 0 to 16, then drain.
   -> almost_full rises when level reaches 12 and falls at 11.
   -> almost_empty is 1 at level <= 3 and 0 at level 4.
5. With level 10, assert flush, wr_en and rd_en together.
   -> Next cycle: level 0, rd_empty = 1, overflow/underflow unchanged.
   -> err_clr together with rd_en on an empty FIFO leaves underflow = 1.
6. Assert rst asynchronously mid-burst at level 7.
   -> Immediately: rd_empty = 1, water_level = 0, overflow = underflow = 0.
   -> After release, a write of 0x3C reads back as 0x3C.
